osd_cfg_sequencer: RTL and testbench

Frame-synchronous register write sequencer for the OSD register write port (mem_wr_valid/addr/data).
- On each frame_start it pushes a burst of OSD register writes: committed shadow config (position, colour, resolution), an auto-incrementing frame number, and the control word.
- Between bursts it arbitrates the single write port to a CPU pass-through requester.
- Sits between the CPU register bridge and the OSD write-register block, so OSD updates land only at frame boundaries.

---
 rtl/osd_cfg_sequencer.sv | 164 ++++++++++++++++
 tb/tb_osd_cfg_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_cfg_sequencer.sv
// Frame-synchronous OSD register write sequencer with CPU pass-through arbitration.
// Optional OSD_SEQ_AUTO_NUM_EN: adds the per-frame OSD_NUM write and a live frame counter.
module osd_cfg_sequencer #(
    parameter logic [31:0] ADDR_CTRL  = 32'h00,
    parameter logic [31:0] ADDR_COORD = 32'h04,
    parameter logic [31:0] ADDR_RGB   = 32'h08,
    parameter logic [31:0] ADDR_NUM   = 32'h0C,
    parameter logic [31:0] ADDR_HRES  = 32'h10,
    parameter logic [31:0] ADDR_VRES  = 32'h14,
    parameter int unsigned NUM_WIDTH  = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 frame_start,
    input  logic [31:0]          cfg_coordinate,
    input  logic [23:0]          cfg_rgb,
    input  logic [15:0]          cfg_h_res,
    input  logic [15:0]          cfg_v_res,
    input  logic                 cfg_en,
    input  logic                 cfg_commit,
    input  logic                 cpu_wr_valid,
    input  logic [31:0]          cpu_wr_addr,
    input  logic [31:0]          cpu_wr_data,
    output logic                 cpu_wr_ready,
    output logic                 mem_wr_valid,
    output logic [31:0]          mem_wr_addr,
    output logic [31:0]          mem_wr_data,
    output logic [NUM_WIDTH-1:0] frame_cnt,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        IDLE, W_COORD, W_RGB, W_HRES, W_VRES, W_NUM, W_CTRL
    } state_t;

`ifdef OSD_SEQ_AUTO_NUM_EN
    localparam state_t AFTER_VRES = W_NUM;
`else
    localparam state_t AFTER_VRES = W_CTRL;
`endif

    state_t state_q, state_d;

    logic [31:0]          coord_q, coord_d;
    logic [23:0]          rgb_q, rgb_d;
    logic [15:0]          hres_q, hres_d;
    logic [15:0]          vres_q, vres_d;
    logic                 pend_q, pend_d;
    logic                 ovr_q, ovr_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [31:0]          wr_addr_q, wr_addr_d;
    logic [31:0]          wr_data_q, wr_data_d;
    logic [NUM_WIDTH-1:0] frame_cnt_d;

    logic in_idle, latch, cpu_accept;

    assign in_idle    = (state_q == IDLE);
    assign latch      = in_idle && frame_start && (pend_q || cfg_commit);
    assign cpu_accept = in_idle && !frame_start && cpu_wr_valid;

    assign cpu_wr_ready = in_idle && !frame_start;
    assign busy         = !in_idle;
    assign overrun      = ovr_q;
    assign mem_wr_valid = wr_valid_q;
    assign mem_wr_addr  = wr_addr_q;
    assign mem_wr_data  = wr_data_q;

`ifdef OSD_SEQ_AUTO_NUM_EN
    logic [NUM_WIDTH-1:0] frame_cnt_q;

    assign frame_cnt_d = frame_start ? frame_cnt_q + NUM_WIDTH'(1) : frame_cnt_q;
    assign frame_cnt   = frame_cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) frame_cnt_q <= '0;
        else          frame_cnt_q <= frame_cnt_d;
    end
`else
    assign frame_cnt_d = '0;
    assign frame_cnt   = '0;
`endif

    // FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state; a frame_start outside IDLE never starts a burst
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = (pend_q || cfg_commit) ? W_COORD : AFTER_VRES;
            W_COORD: state_d = W_RGB;
            W_RGB:   state_d = W_HRES;
            W_HRES:  state_d = W_VRES;
            W_VRES:  state_d = AFTER_VRES;
            W_NUM:   state_d = W_CTRL;
            W_CTRL:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        coord_d = latch ? cfg_coordinate : coord_q;
        rgb_d   = latch ? cfg_rgb        : rgb_q;
        hres_d  = latch ? cfg_h_res      : hres_q;
        vres_d  = latch ? cfg_v_res      : vres_q;
        pend_d  = latch ? 1'b0 : (pend_q || cfg_commit);
        // set beats clear when both happen together
        if (frame_start && !in_idle) ovr_d = 1'b1;
        else if (cfg_commit)         ovr_d = 1'b0;
        else                         ovr_d = ovr_q;
    end

    // Write port decoded from the next state so the write lands with the state it belongs to
    always_comb begin
        wr_valid_d = 1'b1;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        case (state_d)
            IDLE: begin
                wr_valid_d = cpu_accept;
                if (cpu_accept) begin
                    wr_addr_d = cpu_wr_addr;
                    wr_data_d = cpu_wr_data;
                end
            end
            W_COORD: begin wr_addr_d = ADDR_COORD; wr_data_d = coord_d;             end
            W_RGB:   begin wr_addr_d = ADDR_RGB;   wr_data_d = {8'h0, rgb_d};       end
            W_HRES:  begin wr_addr_d = ADDR_HRES;  wr_data_d = {16'h0, hres_d};     end
            W_VRES:  begin wr_addr_d = ADDR_VRES;  wr_data_d = {16'h0, vres_d};     end
            W_NUM:   begin wr_addr_d = ADDR_NUM;   wr_data_d = 32'(frame_cnt_d);    end
            W_CTRL:  begin wr_addr_d = ADDR_CTRL;  wr_data_d = {31'h0, cfg_en};     end
            default: wr_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            coord_q    <= '0;
            rgb_q      <= '0;
            hres_q     <= '0;
            vres_q     <= '0;
            pend_q     <= 1'b0;
            ovr_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            coord_q    <= coord_d;
            rgb_q      <= rgb_d;
            hres_q     <= hres_d;
            vres_q     <= vres_d;
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_osd_cfg_sequencer.sv
// Directed self-checking bench for osd_cfg_sequencer; expectations follow OSD_SEQ_AUTO_NUM_EN.
module tb_osd_cfg_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        frame_start;
    logic [31:0] cfg_coordinate;
    logic [23:0] cfg_rgb;
    logic [15:0] cfg_h_res;
    logic [15:0] cfg_v_res;
    logic        cfg_en;
    logic        cfg_commit;
    logic        cpu_wr_valid;
    logic [31:0] cpu_wr_addr;
    logic [31:0] cpu_wr_data;
    logic        cpu_wr_ready;
    logic        mem_wr_valid;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [15:0] frame_cnt;
    logic        busy;
    logic        overrun;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [15:0] exp_cnt = '0;
    logic        exp_ovr = 1'b0;

    osd_cfg_sequencer #(.NUM_WIDTH(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .frame_start(frame_start),
        .cfg_coordinate(cfg_coordinate), .cfg_rgb(cfg_rgb), .cfg_h_res(cfg_h_res),
        .cfg_v_res(cfg_v_res), .cfg_en(cfg_en), .cfg_commit(cfg_commit),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_wr_ready(cpu_wr_ready), .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .frame_cnt(frame_cnt), .busy(busy), .overrun(overrun)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bump();
`ifdef OSD_SEQ_AUTO_NUM_EN
        exp_cnt++;
`endif
    endtask

    task automatic expect_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, ".valid"}, mem_wr_valid, 1'b1);
        chk({tag, ".addr"}, mem_wr_addr, addr);
        chk({tag, ".data"}, mem_wr_data, data);
        chk({tag, ".busy"}, busy, 1'b1);
        chk({tag, ".ready"}, cpu_wr_ready, 1'b0);
    endtask

    task automatic expect_quiet(input string tag);
        chk({tag, ".q_valid"}, mem_wr_valid, 1'b0);
        chk({tag, ".q_busy"}, busy, 1'b0);
    endtask

    // frame without a pending commit
    task automatic frame_nc(input string tag, input logic en);
        cfg_en = en;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        bump();
`ifdef OSD_SEQ_AUTO_NUM_EN
        expect_wr({tag, ".num"}, 32'h0C, 32'(exp_cnt));
        tick();
`endif
        expect_wr({tag, ".ctrl"}, 32'h00, {31'h0, en});
        chk({tag, ".cnt"}, frame_cnt, exp_cnt);
        tick();
        expect_quiet(tag);
        chk({tag, ".ovr"}, overrun, exp_ovr);
    endtask

    // full burst; cfg inputs are inverted right after the frame edge to prove the snapshot holds.
    // inj: 0 none, 1 frame_start on last write, 2 frame_start+cfg_commit on last write
    task automatic frame_full(input string tag, input logic [31:0] co, input logic [23:0] rg,
                              input logic [15:0] h, input logic [15:0] v, input logic en,
                              input bit commit_same, input int inj);
        cfg_coordinate = co; cfg_rgb = rg; cfg_h_res = h; cfg_v_res = v; cfg_en = en;
        frame_start = 1'b1;
        cfg_commit  = commit_same;
        tick();
        frame_start = 1'b0;
        cfg_commit  = 1'b0;
        bump();
        cfg_coordinate = ~co; cfg_rgb = ~rg; cfg_h_res = ~h; cfg_v_res = ~v;
        expect_wr({tag, ".coord"}, 32'h04, co);
        tick();
        expect_wr({tag, ".rgb"}, 32'h08, {8'h0, rg});
        tick();
        expect_wr({tag, ".hres"}, 32'h10, {16'h0, h});
        tick();
        expect_wr({tag, ".vres"}, 32'h14, {16'h0, v});
        tick();
`ifdef OSD_SEQ_AUTO_NUM_EN
        expect_wr({tag, ".num"}, 32'h0C, 32'(exp_cnt));
        tick();
`endif
        expect_wr({tag, ".ctrl"}, 32'h00, {31'h0, en});
        if (inj > 0) begin
            frame_start = 1'b1;
            cfg_commit  = (inj == 2);
        end
        tick();
        frame_start = 1'b0;
        cfg_commit  = 1'b0;
        if (inj > 0) begin
            bump();
            exp_ovr = 1'b1;
        end
        expect_quiet(tag);
        chk({tag, ".cnt"}, frame_cnt, exp_cnt);
        chk({tag, ".ovr"}, overrun, exp_ovr);
    endtask

    initial begin
        aresetn = 1'b0; frame_start = 1'b0; cfg_commit = 1'b0; cfg_en = 1'b0;
        cfg_coordinate = '0; cfg_rgb = '0; cfg_h_res = '0; cfg_v_res = '0;
        cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
        repeat (3) tick();
        chk("rst.valid", mem_wr_valid, 1'b0);
        chk("rst.addr", mem_wr_addr, 32'h0);
        chk("rst.data", mem_wr_data, 32'h0);
        chk("rst.cnt", frame_cnt, 16'h0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.ovr", overrun, 1'b0);
        chk("rst.ready", cpu_wr_ready, 1'b1);
        aresetn = 1'b1;
        tick();

        frame_nc("nc1", 1'b1);
        frame_nc("nc_en0", 1'b0);

        // commit alone writes nothing; next frame carries the snapshot
        cfg_coordinate = 32'h0020_0040; cfg_rgb = 24'hFF0000; cfg_h_res = 16'h0500; cfg_v_res = 16'h02D0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        expect_quiet("commit_only");
        frame_full("full1", 32'h0020_0040, 24'hFF0000, 16'h0500, 16'h02D0, 1'b1, 1'b0, 0);

        frame_full("commit_same", 32'h1234_5678, 24'hA5C3E1, 16'h0780, 16'h0438, 1'b1, 1'b1, 0);

        // CPU write in IDLE
        cpu_wr_valid = 1'b1; cpu_wr_addr = 32'h08; cpu_wr_data = 32'h0012_3456;
        #1;
        chk("cpu.ready", cpu_wr_ready, 1'b1);
        tick();
        cpu_wr_valid = 1'b0;
        chk("cpu.valid", mem_wr_valid, 1'b1);
        chk("cpu.addr", mem_wr_addr, 32'h08);
        chk("cpu.data", mem_wr_data, 32'h0012_3456);
        chk("cpu.busy", busy, 1'b0);
        tick();
        chk("cpu.after", mem_wr_valid, 1'b0);

        // frame_start beats a simultaneous CPU request; CPU holds valid
        cpu_wr_valid = 1'b1; cpu_wr_addr = 32'h14; cpu_wr_data = 32'h0000_CAFE;
        frame_start = 1'b1;
        #1;
        chk("arb.ready0", cpu_wr_ready, 1'b0);
        frame_nc("arb", 1'b1);
        chk("arb.ready1", cpu_wr_ready, 1'b1);
        tick();
        cpu_wr_valid = 1'b0;
        chk("arb.valid", mem_wr_valid, 1'b1);
        chk("arb.addr", mem_wr_addr, 32'h14);
        chk("arb.data", mem_wr_data, 32'h0000_CAFE);
        tick();
        chk("arb.after", mem_wr_valid, 1'b0);

        // frame_start while busy: counted, overrun set, no new burst
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        frame_full("ovr", 32'h0001_0002, 24'h010203, 16'h0100, 16'h0080, 1'b1, 1'b0, 1);
        tick();
        expect_quiet("ovr.nonew");
        chk("ovr.sticky", overrun, 1'b1);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        exp_ovr = 1'b0;
        chk("ovr.clear", overrun, 1'b0);

        // commit + frame_start while busy: overrun set wins, old snapshot used, new one next frame
        frame_full("setwins", 32'h0AAA_0555, 24'h00FF00, 16'h0320, 16'h0258, 1'b1, 1'b0, 2);
        frame_full("newsnap", ~32'h0AAA_0555, ~24'h00FF00, ~16'h0320, ~16'h0258, 1'b1, 1'b0, 0);

`ifdef OSD_SEQ_AUTO_NUM_EN
        begin
            int unsigned n;
            n = 32'(16'hFFFF - exp_cnt);
            frame_start = 1'b1;
            for (int unsigned i = 0; i < n; i++) tick();
            frame_start = 1'b0;
            exp_cnt = 16'hFFFF;
            exp_ovr = 1'b1;
            repeat (8) tick();
            chk("wrap.pre_cnt", frame_cnt, 16'hFFFF);
            chk("wrap.pre_valid", mem_wr_valid, 1'b0);
        end
`endif
        frame_nc("wrap", 1'b1);

        // reset asserted during the 3rd write of a full burst
        cfg_coordinate = 32'h0003_0004; cfg_rgb = 24'h112233; cfg_h_res = 16'h0040; cfg_v_res = 16'h0030;
        frame_start = 1'b1; cfg_commit = 1'b1;
        tick();
        frame_start = 1'b0; cfg_commit = 1'b0;
        bump();
        expect_wr("mid.coord", 32'h04, 32'h0003_0004);
        tick();
        expect_wr("mid.rgb", 32'h08, 32'h0011_2233);
        tick();
        expect_wr("mid.hres", 32'h10, 32'h0000_0040);
        aresetn = 1'b0;
        #1;
        chk("mid.valid", mem_wr_valid, 1'b0);
        chk("mid.addr", mem_wr_addr, 32'h0);
        chk("mid.data", mem_wr_data, 32'h0);
        chk("mid.busy", busy, 1'b0);
        chk("mid.cnt", frame_cnt, 16'h0);
        chk("mid.ovr", overrun, 1'b0);
        exp_cnt = '0;
        exp_ovr = 1'b0;
        tick();
        aresetn = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            tick();
            expect_quiet("post_rst.idle");
        end
        frame_nc("post_rst", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
